pipe_stage_elastic: RTL and testbench



---
 rtl/pipe_stage_elastic_pkg.sv | 22 ++
 rtl/pipe_stage_elastic_sat_counter.sv | 21 ++
 rtl/pipe_stage_elastic.sv | 111 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline constants: stage bundle widths, NOP encodings
// and the elastic stage occupancy states.
package pipe_stage_elastic_pkg;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 159;
    localparam int EX_MEM_W = 111;
    localparam int MEM_WB_W = 71;

    // IF/ID NOP carries addi x0,x0,0 so a bubble decodes harmlessly
    localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = {32'h0, 32'h0000_0013};
    localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = '0;
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;
    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = '0;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } stage_state_e;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over
// increment.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with optional skid entry,
// flush-to-bubble and a saturating stall counter.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int               WIDTH  = 64,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             clr_cnt
);

    stage_state_e     state;
    stage_state_e     state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             ready_raw;
    logic             accept;
    logic             emit;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;

    // With a skid entry, readiness depends only on occupancy flops
    assign ready_raw = SKID ? (state != ST_FULL)
                            : (!out_valid || out_ready);
    assign in_ready  = ready_raw && !rst && !flush;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end else if (emit) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    state_nxt      = ST_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            state <= state_nxt;
            if (flush) begin
                main_q <= BUBBLE;
            end else if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    pipe_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid && !out_ready && !flush),
        .clr  (clr_cnt),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic (WIDTH=8, SKID=1,
// CNT_W=4, non-zero bubble).
module tb_pipe_stage_elastic;

    localparam int         W   = 8;
    localparam int         CW  = 4;
    localparam logic [7:0] BUB = 8'hEE;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt;
    logic          clr_cnt;

    logic [W-1:0] exp_q[$];
    int           n_chk  = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .WIDTH (W),
        .SKID  (1'b1),
        .BUBBLE(BUB),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stall_cnt(stall_cnt),
        .clr_cnt  (clr_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every emitted word must be the oldest expected one
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_emit", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("emit_order", {24'h0, out_data},
                    {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; flush = 0; clr_cnt = 0;
        in_valid = 1; in_data = 8'hAA; out_ready = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 32'(BUB));
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        tick();
        rst = 0; in_valid = 0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_out_valid", 32'(out_valid), 0);
        tick();

        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_data = 8'(i);
            exp_q.push_back(8'(i));
            @(negedge clk);
            chk("stream_in_ready", 32'(in_ready), 1);
            if (i > 1) chk("stream_no_gap", 32'(out_valid), 1);
            tick();
        end
        in_valid = 0;
        @(negedge clk);
        chk("stream_last_valid", 32'(out_valid), 1);
        tick();
        @(negedge clk);
        chk("stream_drained", 32'(out_valid), 0);
        chk("empty_keeps_data", 32'(out_data), 32'h08);
        tick();

        out_ready = 0; in_valid = 1; in_data = 8'h11;
        exp_q.push_back(8'h11);
        @(negedge clk);
        chk("bp_a_in_ready", 32'(in_ready), 1);
        tick();
        in_data = 8'h22;
        exp_q.push_back(8'h22);
        @(negedge clk);
        chk("bp_b_in_ready", 32'(in_ready), 1);
        chk("bp_b_out_data", 32'(out_data), 32'h11);
        tick();
        in_data = 8'h33;
        @(negedge clk);
        chk("bp_c_in_ready", 32'(in_ready), 0);
        tick();
        @(negedge clk);
        chk("bp_d_in_ready", 32'(in_ready), 0);
        chk("bp_d_hold_data", 32'(out_data), 32'h11);
        chk("bp_d_hold_valid", 32'(out_valid), 1);
        tick();
        @(negedge clk);
        chk("bp_e_in_ready", 32'(in_ready), 0);
        tick();
        out_ready = 1;
        @(negedge clk);
        chk("bp_stall_cnt", 32'(stall_cnt), 4);
        chk("bp_f_in_ready", 32'(in_ready), 0);
        tick();
        exp_q.push_back(8'h33);
        @(negedge clk);
        chk("bp_g_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("bp_h_out_data", 32'(out_data), 32'h33);
        tick();
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 0);
        chk("bp_cnt_hold", 32'(stall_cnt), 4);
        tick();

        clr_cnt = 1;
        tick();
        clr_cnt = 0; out_ready = 0; in_valid = 1; in_data = 8'h11;
        @(negedge clk);
        chk("clr_cnt_zero", 32'(stall_cnt), 0);
        tick();
        in_data = 8'h22;
        tick();
        flush = 1; in_data = 8'h55;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 0);
        tick();
        flush = 0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_out_data", 32'(out_data), 32'(BUB));
        chk("flush_in_ready_after", 32'(in_ready), 1);
        chk("flush_stall_cnt", 32'(stall_cnt), 1);
        exp_q.push_back(8'h55);
        tick();
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("flush_55_data", 32'(out_data), 32'h55);
        tick();

        out_ready = 0; clr_cnt = 1; in_valid = 1; in_data = 8'h77;
        exp_q.push_back(8'h77);
        tick();
        clr_cnt = 0; in_valid = 0;
        repeat (20) tick();
        @(negedge clk);
        chk("sat_cnt", 32'(stall_cnt), 15);
        tick();
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        @(negedge clk);
        chk("sat_clr", 32'(stall_cnt), 0);
        tick(); tick(); tick();
        @(negedge clk);
        chk("sat_resume", 32'(stall_cnt), 3);
        tick();
        out_ready = 1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("final_empty", 32'(out_valid), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
